rightrotate_seq: RTL and testbench
==================================

Name: rightrotate_seq

Overview:
- Multi-cycle right rotator for the MD5 datapath; the inverse direction of the combinational left rotator.
- Undoes or checks leftrotate results with an iterative shifter instead of a full barrel rotator, for area-constrained builds.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two, at least 2.
- STEP, 1, maximum bits rotated per cycle; legal range 1..WIDTH-1.
- AW, $clog2(WIDTH) (=5), width of the shift amount.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  WIDTH  word to rotate.
- shift_amount  input  AW  right-rotate amount, 0..WIDTH-1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  rotated word.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, out_data=0, internal remaining count=0. in_ready=1 once reset deasserts.
- Reset mid-operation aborts immediately. The partial result is discarded and no out_valid pulse occurs.
- States: IDLE, ROTATE, DONE. in_ready = (state==IDLE), combinational from state only. out_valid = (state==DONE).
- IDLE: on in_valid & in_ready at an edge:
  - latch in_data into the working register (out_data) and shift_amount into remaining;
  - go to ROTATE if shift_amount != 0, else go to DONE.
- ROTATE, each edge:
  - k = min(STEP, remaining);
  - out_data <= rotate-right(out_data, k), so bits leaving bit 0 re-enter at bit WIDTH-1;
  - remaining <= remaining - k;
  - if remaining - k == 0, go to DONE.
- DONE: hold out_data and out_valid stable until out_ready=1 at an edge, then go to IDLE. out_data keeps its last value in IDLE.
- Latency, in edges from the accept edge to out_valid first visible: 1 if shift_amount==0, else 1 + ceil(shift_amount/STEP). With STEP=1, amount 31 gives 32 edges.
- No overlap: a new request is not accepted in the cycle the result is consumed. The earliest next accept is the following edge (in_ready high in IDLE).
- Inputs in_data and shift_amount are sampled only at the accept edge. Later changes have no effect.
- out_ready while not in DONE is ignored. in_valid while not in IDLE is ignored; the requester must hold it.
- Arithmetic: remaining is AW bits wide and never underflows, because k <= remaining.

Optional Feature:
- Macro ROTATE_DIR_SEL_EN.
- Defined:
  - adds input port dir_left (1 bit), sampled at the accept edge;
  - dir_left=1 loads remaining = (WIDTH - shift_amount) mod WIDTH, giving a left rotate by shift_amount with the same datapath;
  - latency follows the loaded remaining value;
  - dir_left=0 is identical to the base behaviour.
- Not defined: no dir_left port; right rotate only.

Test Plan (WIDTH=32, STEP=1, in_data=0xF387551A):
- Reset: assert rst_n=0 mid-run -> out_valid=0, out_data=0, in_ready=1 after release. Then shift_amount=1 -> out_data=0x79C3AA8D after 2 edges.
- shift_amount=5 -> out_data=0xD79C3AA8, out_valid on edge 6. Hold out_ready=0 for 4 cycles -> data stable and in_ready=0 throughout.
- shift_amount=31 -> out_data=0xE70EAA35 (equals left-rotate by 1) on edge 32.
- shift_amount=0 -> out_data=0xF387551A, out_valid after 1 edge. in_valid pulsed during DONE is ignored.
- Back-to-back: requests with amounts 1 then 5, out_ready tied 1 -> exactly two results in order (0x79C3AA8D, 0xD79C3AA8), one IDLE cycle between them.
- STEP=4, amount 5, plus ROTATE_DIR_SEL_EN:
  - STEP=4, amount 5 -> 0xD79C3AA8 after 3 edges;
  - dir_left=1, amount 1 -> 0xE70EAA35.

Source files
------------

// File: rtl/rightrotate_seq.sv
// rightrotate_seq
// ---------------
// Multi-cycle right rotator for the MD5 datapath. It is the inverse of the
// combinational left rotator. An iterative shifter moves at most STEP bits
// per clock, so it is much smaller than a full barrel rotator.
//
// Handshake:
//   - A transfer happens on a rising edge where valid & ready are both 1.
//   - A producer holds valid and its payload stable until that edge.
//   - The side that raises ready may not make it depend on valid.
//   - in_ready is high only in IDLE; out_valid is high only in DONE.
//   - Only one operation is in flight at a time.
//
// Parameters:
//   WIDTH - data width; a power of two, at least 2.
//   STEP  - maximum bits rotated per clock, 1..WIDTH-1.
//   AW    - width of the shift amount, $clog2(WIDTH).
//
// Ports:
//   clk          - clock; all state changes on the rising edge.
//   rst_n        - asynchronous, active-low reset.
//   dir_left     - (ROTATE_DIR_SEL_EN only) 1 = rotate left instead of right.
//   in_valid     - request valid.
//   in_ready     - the block can accept a request.
//   in_data      - word to rotate; sampled only at the accept edge.
//   shift_amount - rotate amount, 0..WIDTH-1; sampled only at the accept edge.
//   out_valid    - result valid.
//   out_ready    - the consumer accepts the result.
//   out_data     - working register, holding the rotated word.
//
// Build option:
//   ROTATE_DIR_SEL_EN - when defined, adds the dir_left port.
//   A left rotate by n is run as a right rotate by (WIDTH - n) mod WIDTH.
//
// The FSM state is the `state` signal (type state_t) inside this module.

module rightrotate_seq #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ROTATE_DIR_SEL_EN
  input  logic             dir_left,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    shift_amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [AW-1:0] STEP_W = AW'(STEP);

  state_t           state;
  state_t           state_nxt;
  logic [AW-1:0]    remaining;
  logic [AW-1:0]    remaining_nxt;
  logic [AW-1:0]    load_amount;
  logic [AW-1:0]    step_k;
  logic [WIDTH-1:0] rotated;
  logic [WIDTH-1:0] data_nxt;

  // WIDTH is a power of two, so (WIDTH - n) mod WIDTH is plain AW-bit
  // negation. Amount 0 stays 0 and goes straight to DONE.
`ifdef ROTATE_DIR_SEL_EN
  assign load_amount = dir_left ? (AW'(0) - shift_amount) : shift_amount;
`else
  assign load_amount = shift_amount;
`endif

  // k = min(STEP, remaining). Because k <= remaining, remaining never underflows.
  assign step_k = (remaining < STEP_W) ? remaining : STEP_W;

  // Rotate right by step_k: bit i takes bit (i + k) mod WIDTH, so bits that
  // leave bit 0 come back in at the top.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rotated[i] = out_data[(i + int'(step_k)) % WIDTH];
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    data_nxt      = out_data;
    case (state)
      IDLE: begin
        if (in_valid) begin
          data_nxt      = in_data;
          remaining_nxt = load_amount;
          state_nxt     = (load_amount == '0) ? DONE : ROTATE;
        end
      end
      ROTATE: begin
        data_nxt      = rotated;
        remaining_nxt = remaining - step_k;
        if (remaining == step_k) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // The result stays put until it is consumed. A new request waits
        // for IDLE, so requests never overlap.
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      out_data  <= data_nxt;
    end
  end

endmodule

// File: tb/tb_rightrotate_seq.sv
// tb_rightrotate_seq
// ------------------
// Directed bench for rightrotate_seq. It uses two instances:
//   - u_dut  : WIDTH=32, STEP=1 (main instance).
//   - u_dut4 : WIDTH=32, STEP=4 (multi-bit step; dir_left when the macro is defined).
// Expected words and latencies are worked out by hand from the rotate definition.

module tb_rightrotate_seq;

  localparam int W  = 32;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (STEP=1) ----------------
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] shift_amount = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;

  // ---------------- DUT (STEP=4) ----------------
  logic          in_valid_4 = 1'b0;
  logic          in_ready_4;
  logic [W-1:0]  in_data_4 = '0;
  logic [AW-1:0] shift_amount_4 = '0;
  logic          out_valid_4;
  logic          out_ready_4 = 1'b0;
  logic [W-1:0]  out_data_4;

`ifdef ROTATE_DIR_SEL_EN
  logic dir_left   = 1'b0;
  logic dir_left_4 = 1'b0;
`endif

  rightrotate_seq #(.WIDTH(W), .STEP(1)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef ROTATE_DIR_SEL_EN
    .dir_left     (dir_left),
`endif
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .shift_amount (shift_amount),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
  );

  rightrotate_seq #(.WIDTH(W), .STEP(4)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef ROTATE_DIR_SEL_EN
    .dir_left     (dir_left_4),
`endif
    .in_valid     (in_valid_4),
    .in_ready     (in_ready_4),
    .in_data      (in_data_4),
    .shift_amount (shift_amount_4),
    .out_valid    (out_valid_4),
    .out_ready    (out_ready_4),
    .out_data     (out_data_4)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0]  data;
    logic [AW-1:0] amt;
    logic [W-1:0]  exp;
    int            lat;   // edges from the accept edge to out_valid
    int            hold;  // cycles out_ready is held low during DONE
    bit            poke;  // pulse in_valid during DONE
  } vec_t;

  vec_t vecs[9];

  // ---------------- driver tasks ----------------
  task automatic run_op(input vec_t v, input string name);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_in_ready"}, W'(in_ready), W'(1));
    @(negedge clk);
    in_valid     = 1'b1;
    in_data      = v.data;
    shift_amount = v.amt;
    @(posedge clk); #1;
    // Scramble the inputs after the accept edge; they must not matter now.
    in_valid     = 1'b0;
    in_data      = $urandom;
    shift_amount = AW'($urandom_range(0, 31));
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_latency"}, W'(n), W'(v.lat));
    check({name, "_data"}, out_data, v.exp);
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      check({name, "_hold_valid"}, W'(out_valid), W'(1));
      check({name, "_hold_data"}, out_data, v.exp);
      check({name, "_hold_in_ready"}, W'(in_ready), W'(0));
    end
    if (v.poke) begin
      @(negedge clk);
      in_valid     = 1'b1;
      in_data      = ~v.data;
      shift_amount = AW'(3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({name, "_poke_data"}, out_data, v.exp);
      check({name, "_poke_valid"}, W'(out_valid), W'(1));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_consumed_valid"}, W'(out_valid), W'(0));
    check({name, "_consumed_in_ready"}, W'(in_ready), W'(1));
    check({name, "_idle_keeps_data"}, out_data, v.exp);
  endtask

  task automatic run4(input logic [AW-1:0] amt, input bit dir, input logic [W-1:0] exp,
                      input int lat, input string name);
    int n;
    n = 0;
    while (!in_ready_4 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk);
    in_valid_4     = 1'b1;
    in_data_4      = 32'hF387551A;
    shift_amount_4 = amt;
`ifdef ROTATE_DIR_SEL_EN
    dir_left_4     = dir;
`else
    if (dir) $display("note: dir_left not built; %s skipped", name);
`endif
    @(posedge clk); #1;
    in_valid_4 = 1'b0;
    n = 1;
    while (!out_valid_4 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_latency"}, W'(n), W'(lat));
    check({name, "_data"}, out_data_4, exp);
    @(negedge clk);
    out_ready_4 = 1'b1;
    @(posedge clk); #1;
    out_ready_4 = 1'b0;
`ifdef ROTATE_DIR_SEL_EN
    dir_left_4 = 1'b0;
`endif
    check({name, "_consumed_valid"}, W'(out_valid_4), W'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit saw;
    int sent, results, last_consume;
    logic [AW-1:0] b2b_amt[2];
    logic [W-1:0]  b2b_exp[2];

    //            data          amt  expected      lat hold poke
    vecs[0] = '{32'hF387551A,  1, 32'h79C3AA8D,   2, 0, 0};
    vecs[1] = '{32'hF387551A,  5, 32'hD79C3AA8,   6, 4, 0};
    vecs[2] = '{32'hF387551A, 31, 32'hE70EAA35,  32, 0, 0};
    vecs[3] = '{32'hF387551A,  0, 32'hF387551A,   1, 0, 1};
    vecs[4] = '{32'hF387551A,  4, 32'hAF387551,   5, 0, 0};
    vecs[5] = '{32'hF387551A, 16, 32'h551AF387,  17, 0, 0};
    vecs[6] = '{32'h80000001,  1, 32'hC0000000,   2, 0, 0};
    vecs[7] = '{32'h12345678, 12, 32'h67812345,  13, 0, 0};
    vecs[8] = '{32'h00000001, 31, 32'h00000002,  32, 2, 0};

    // Reset state.
    #1;
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_out_data", out_data, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", W'(in_ready), W'(1));

    // Reset in the middle of a rotate aborts it with no result pulse.
    @(negedge clk);
    in_valid     = 1'b1;
    in_data      = 32'hF387551A;
    shift_amount = AW'(5);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_out_data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", W'(in_ready), W'(1));
    saw = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) saw = 1'b1;
    end
    check("midrst_no_pulse", W'(saw), W'(0));

    // Table-driven vectors on the STEP=1 instance.
    foreach (vecs[i]) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: out_ready tied high, two requests issued as soon as
    // in_ready allows. The second accept must come one cycle after the first
    // result is consumed.
    b2b_amt[0] = AW'(1); b2b_exp[0] = 32'h79C3AA8D;
    b2b_amt[1] = AW'(5); b2b_exp[1] = 32'hD79C3AA8;
    sent = 0; results = 0; last_consume = -10;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        results++;
        last_consume = cyc;
        if (exp_q.size() > 0) begin
          check($sformatf("b2b_result%0d", results), out_data, exp_q.pop_front());
        end else begin
          check("b2b_extra_result", W'(results), W'(0));
        end
      end
      if (in_ready && sent < 2) begin
        if (sent == 1) check("b2b_idle_gap", W'(cyc - last_consume), W'(1));
        in_valid     = 1'b1;
        in_data      = 32'hF387551A;
        shift_amount = b2b_amt[sent];
        exp_q.push_back(b2b_exp[sent]);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b_results", W'(results), W'(2));
    check("b2b_queue_empty", W'(exp_q.size()), W'(0));

    // STEP=4 instance: latency is 1 + ceil(amount/4).
    run4(AW'(5),  1'b0, 32'hD79C3AA8, 3, "step4_amt5");
    run4(AW'(31), 1'b0, 32'hE70EAA35, 9, "step4_amt31");
    run4(AW'(4),  1'b0, 32'hAF387551, 2, "step4_amt4");
`ifdef ROTATE_DIR_SEL_EN
    // Left by 1 loads remaining 31: 1 + ceil(31/4) = 9 edges.
    run4(AW'(1),  1'b1, 32'hE70EAA35, 9, "step4_left1");
    run4(AW'(0),  1'b1, 32'hF387551A, 1, "step4_left0");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
